ram_copy_engine: RTL and testbench

- Initiator-side block-transfer engine that drives the synchronous byte RAM port: address, write data, write enable, read enable, and captures read data.
- Copies `length` bytes from `src_addr` to `dst_addr` on a single start pulse. This frees the core from byte-by-byte load/store loops during memory initialisation and buffer moves.
- Sits between the core's control registers and the RAM's single port. It owns that port while busy.

---
 rtl/ram_copy_engine.sv | 137 +++++++++++++
 tb/tb_ram_copy_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - RAM block copy engine (optional fill mode under RAM_COPY_FILL_EN)
module ram_copy_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef RAM_COPY_FILL_EN
    input  logic                  fill_mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  bytes_done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = '0;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q, addr_hold_q;
    logic [LEN_WIDTH-1:0]  rem_q, bytes_q;
    logic                  fill_q;
    logic [DATA_WIDTH-1:0] fill_val_q;
    logic                  start_fill;
    logic [DATA_WIDTH-1:0] start_fill_val;

`ifdef RAM_COPY_FILL_EN
    assign start_fill     = fill_mode;
    assign start_fill_val = fill_value;
`else
    assign start_fill     = 1'b0;
    assign start_fill_val = '0;
`endif

    assign bytes_done = bytes_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and RAM port drive; address holds its last value when idle
    always_comb begin
        state_d          = state_q;
        busy             = 1'b0;
        done             = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = addr_hold_q;
        mem_wdata        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == LEN_ZERO) begin
                        state_d = S_FIN;
                    end else if (start_fill) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                busy            = 1'b1;
                mem_read_enable = 1'b1;
                mem_address     = src_q;
                state_d         = abort ? S_FIN : S_WR;
            end
            S_WR: begin
                busy             = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = dst_q;
                mem_wdata        = fill_q ? fill_val_q : mem_rdata;
                if (rem_q == LEN_ONE || abort) begin
                    state_d = S_FIN;
                end else begin
                    state_d = fill_q ? S_WR : S_RD;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: latch request on start, advance pointers after each write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            bytes_q     <= '0;
            fill_q      <= 1'b0;
            fill_val_q  <= '0;
            addr_hold_q <= '0;
        end else begin
            if (state_q == S_RD || state_q == S_WR) begin
                addr_hold_q <= mem_address;
            end
            if (state_q == S_IDLE && start) begin
                src_q      <= src_addr;
                dst_q      <= dst_addr;
                rem_q      <= length;
                bytes_q    <= '0;
                fill_q     <= start_fill;
                fill_val_q <= start_fill_val;
            end else if (state_q == S_WR) begin
                src_q   <= src_q + ADDR_ONE;
                dst_q   <= dst_q + ADDR_ONE;
                rem_q   <= rem_q - LEN_ONE;
                bytes_q <= bytes_q + LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - scoreboard bench for ram_copy_engine
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] length = '0;
`ifdef RAM_COPY_FILL_EN
    logic        fill_mode = 1'b0;
    logic [7:0]  fill_value = '0;
`endif
    logic        busy, done;
    logic [15:0] bytes_done;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_write_enable, mem_read_enable;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  ram [0:65535];
    logic [23:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int re_cnt = 0, we_cnt = 0, done_cnt = 0, overlap = 0;

    ram_copy_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
`ifdef RAM_COPY_FILL_EN
        .fill_mode        (fill_mode),
        .fill_value       (fill_value),
`endif
        .busy             (busy),
        .done             (done),
        .bytes_done       (bytes_done),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM model: registered read data, write on strobe
    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address] <= mem_wdata;
        if (mem_read_enable) mem_rdata <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Port monitor: strobe counts and scoreboard pop on every write
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read_enable) re_cnt++;
            if (mem_read_enable && mem_write_enable) overlap++;
            if (done) done_cnt++;
            if (mem_write_enable) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_address), 32'(e[23:8]));
                    check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic clear_counts();
        re_cnt = 0; we_cnt = 0; done_cnt = 0; overlap = 0;
    endtask

    task automatic drive_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input bit fm, input logic [7:0] fv);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
`ifdef RAM_COPY_FILL_EN
        fill_mode = fm; fill_value = fv;
`endif
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input int n_wr, input int abort_at,
                            input bit fm, input logic [7:0] fv, input int exp_dc);
        int  dc;
        bit  fired;
        for (int i = 0; i < n_wr; i++) begin
            logic [15:0] sa;
            sa = s + 16'(i);
            exp_q.push_back({d + 16'(i), fm ? fv : ram[sa]});
        end
        clear_counts();
        drive_start(s, d, l, fm, fv);
        dc = 0;
        fired = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            #1;
            if (abort_at > 0 && !fired && we_cnt == abort_at) begin
                abort = 1'b1;
                fired = 1'b1;
            end else begin
                abort = 1'b0;
            end
            if (done_cnt > 0 && dc == 0) dc = k;
            if (dc != 0 && k >= dc + 3) break;
        end
        abort = 1'b0;
        check({tag, "_done_cycle"}, 32'(dc), 32'(exp_dc));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_bytes_done"}, 32'(bytes_done), 32'(n_wr));
        check({tag, "_writes"}, 32'(we_cnt), 32'(n_wr));
        check({tag, "_reads"}, 32'(re_cnt), fm ? 32'd0 : 32'(n_wr));
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        ram[16'h0010] <= 8'hAA; ram[16'h0011] <= 8'hBB;
        ram[16'h0012] <= 8'hCC; ram[16'h0013] <= 8'hDD;
        ram[16'hFFFE] <= 8'h01; ram[16'hFFFF] <= 8'h02;
        ram[16'h0000] <= 8'h03; ram[16'h0001] <= 8'h04;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bytes", 32'(bytes_done), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer("copy4", 16'h0010, 16'h0080, 16'd4, 4, 0, 1'b0, 8'h00, 9);
        check("ram80", 32'(ram[16'h0080]), 32'hAA);
        check("ram83", 32'(ram[16'h0083]), 32'hDD);
        check("idle_addr_hold", 32'(mem_address), 32'h0083);

        run_xfer("empty", 16'h0010, 16'h0200, 16'd0, 0, 0, 1'b0, 8'h00, 1);

        run_xfer("wrap", 16'hFFFE, 16'h0100, 16'd4, 4, 0, 1'b0, 8'h00, 9);
        check("ram103", 32'(ram[16'h0103]), 32'h04);

        run_xfer("abort", 16'h0010, 16'h0300, 16'd8, 3, 3, 1'b0, 8'h00, 7);

        // Reset during the second RD cycle
        exp_q.push_back({16'h0400, 8'hAA});
        clear_counts();
        drive_start(16'h0010, 16'h0400, 16'd4, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd0);
        check("mid_rst_bytes", 32'(bytes_done), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        check("mid_rst_writes", 32'(we_cnt), 32'd1);
        exp_q.delete();

        run_xfer("after_rst", 16'h0010, 16'h0500, 16'd4, 4, 0, 1'b0, 8'h00, 9);

`ifdef RAM_COPY_FILL_EN
        run_xfer("fill", 16'h0010, 16'h0020, 16'd3, 3, 0, 1'b1, 8'h5A, 4);
        check("ram22", 32'(ram[16'h0022]), 32'h5A);
        run_xfer("fill_off", 16'h0010, 16'h0600, 16'd2, 2, 0, 1'b0, 8'h5A, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
